beta_data_mem_responder: RTL

- Memory-side responder for the core's data memory port: serves the separate read (rdata_*) and write (wdata_*) request channels from one word-organised storage array.
- Used as the data TCM in simulation and FPGA bring-up, behind the core's LSU.
- Fixed, parameterised response latency, with an optional random-stall mode to stress the core's multi-cycle memory handling.

---
 rtl/beta_data_mem_responder_if.sv | 45 ++++
 rtl/beta_data_mem_responder.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/beta_data_mem_responder_if.sv
`default_nettype none
// ============================================================================
//  Module   : beta_data_mem_responder_if
//  Purpose  : Read/write request and response channels between the core's
//             LSU (master) and the data memory responder (slave).
//  Revision : 1.0  initial release
// ============================================================================
interface beta_data_mem_responder_if #(
   parameter int DataWidth    = 32,
   parameter int AddressWidth = 32
);
   // Read channel
   logic                      rdata_req_i;
   logic [AddressWidth-1:0]   rdata_addr_i;
   logic [DataWidth/8-1:0]    rdata_strb_i;
   logic                      rdata_ready_o;
   logic                      rdata_valid_o;
   logic [DataWidth-1:0]      rdata_data_o;

   // Write channel
   logic                      wdata_req_i;
   logic [AddressWidth-1:0]   wdata_addr_i;
   logic [DataWidth/8-1:0]    wdata_strb_i;
   logic [DataWidth-1:0]      wdata_data_i;
   logic                      wdata_ready_o;
   logic                      wdata_valid_o;

   // Status
   logic                      oor_flag_o;

   modport master (
      output rdata_req_i, rdata_addr_i, rdata_strb_i,
      output wdata_req_i, wdata_addr_i, wdata_strb_i, wdata_data_i,
      input  rdata_ready_o, rdata_valid_o, rdata_data_o,
      input  wdata_ready_o, wdata_valid_o, oor_flag_o
   );

   modport slave (
      input  rdata_req_i, rdata_addr_i, rdata_strb_i,
      input  wdata_req_i, wdata_addr_i, wdata_strb_i, wdata_data_i,
      output rdata_ready_o, rdata_valid_o, rdata_data_o,
      output wdata_ready_o, wdata_valid_o, oor_flag_o
   );
endinterface
`default_nettype wire

// File: rtl/beta_data_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module   : beta_data_mem_responder
//  Purpose  : Data-memory responder serving separate read and write request
//             channels from one word-organised storage array with a fixed,
//             parameterised response latency. Read has priority over write.
//  Option   : define BETA_DMEM_RAND_STALL_EN to add 0-3 pseudo-random extra
//             wait cycles per access (8-bit LFSR, taps 8,6,5,4).
//  Revision : 1.0  initial release
// ============================================================================
module beta_data_mem_responder #(
   parameter int                     DataWidth     = 32,
   parameter int                     AddressWidth  = 32,
   parameter int                     MemDepthWords = 1024,
   parameter int                     Latency       = 1,
   parameter logic [AddressWidth-1:0] BaseAddr     = '0
) (
   input  wire logic                 clk_i,
   input  wire logic                 rst_i,
   beta_data_mem_responder_if.slave  bus
);

   localparam int NumBytes = DataWidth / 8;
   localparam int IdxW     = (MemDepthWords > 1) ? $clog2(MemDepthWords) : 1;
   localparam int CntW     = 5;   // holds Latency-1 plus up to 3 stall cycles
   localparam logic [AddressWidth-1:0] DepthA = AddressWidth'(MemDepthWords);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } state_e;

   state_e                 state_q;
   logic [CntW-1:0]        cnt_q;
   logic                   op_rd_q;
   logic                   rvalid_q;
   logic                   wvalid_q;
   logic [DataWidth-1:0]   rdata_q;
   logic                   oor_q;

   logic [DataWidth-1:0]   mem_q [MemDepthWords];

   logic                   idle_d;
   logic                   rd_ready_d;
   logic                   wr_ready_d;
   logic                   rd_acc_d;
   logic                   wr_acc_d;
   logic [AddressWidth-1:0] rd_off_d;
   logic [AddressWidth-1:0] wr_off_d;
   logic                   rd_in_rng_d;
   logic                   wr_in_rng_d;
   logic [IdxW-1:0]        rd_idx_d;
   logic [IdxW-1:0]        wr_idx_d;
   logic [DataWidth-1:0]   rd_word_d;
   logic                   oor_acc_d;
   logic [CntW-1:0]        extra_d;
   logic [CntW-1:0]        wait_total_d;

   // Handshake: requests are only seen in IDLE; read beats write on a tie.
   assign idle_d     = (state_q == ST_IDLE) && !rst_i;
   assign rd_ready_d = idle_d;
   assign wr_ready_d = idle_d && !bus.rdata_req_i;
   assign rd_acc_d   = bus.rdata_req_i && rd_ready_d;
   assign wr_acc_d   = bus.wdata_req_i && wr_ready_d;

   // Address decode: the two low address bits are ignored.
   assign rd_off_d    = bus.rdata_addr_i - BaseAddr;
   assign wr_off_d    = bus.wdata_addr_i - BaseAddr;
   assign rd_in_rng_d = (bus.rdata_addr_i >= BaseAddr) && ((rd_off_d >> 2) < DepthA);
   assign wr_in_rng_d = (bus.wdata_addr_i >= BaseAddr) && ((wr_off_d >> 2) < DepthA);
   assign rd_idx_d    = IdxW'(rd_off_d >> 2);
   assign wr_idx_d    = IdxW'(wr_off_d >> 2);
   assign oor_acc_d   = (rd_acc_d && !rd_in_rng_d) || (wr_acc_d && !wr_in_rng_d);

   // Read word with disabled bytes and out-of-range accesses forced to zero.
   always_comb begin
      rd_word_d = '0;
      for (int b = 0; b < NumBytes; b++) begin
         if (rd_in_rng_d && bus.rdata_strb_i[b]) begin
            rd_word_d[8*b +: 8] = mem_q[rd_idx_d][8*b +: 8];
         end
      end
   end

`ifdef BETA_DMEM_RAND_STALL_EN
   logic [7:0] lfsr_q;
   logic       lfsr_fb_d;

   assign lfsr_fb_d = lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3];
   assign extra_d   = {{(CntW-2){1'b0}}, lfsr_q[1:0]};

   // Free-running stall generator, reseeded on reset.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         lfsr_q <= 8'hA5;
      end else begin
         lfsr_q <= {lfsr_q[6:0], lfsr_fb_d};
      end
   end
`else
   assign extra_d = '0;
`endif

   // Number of WAIT cycles between acceptance and the response cycle.
   assign wait_total_d = CntW'(Latency - 1) + extra_d;

   // Storage write port: byte-masked commit at the acceptance edge; never reset.
   always_ff @(posedge clk_i) begin
      if (wr_acc_d && wr_in_rng_d) begin
         for (int b = 0; b < NumBytes; b++) begin
            if (bus.wdata_strb_i[b]) begin
               mem_q[wr_idx_d][8*b +: 8] <= bus.wdata_data_i[8*b +: 8];
            end
         end
      end
   end

   // Control FSM with registered valid pulses, read data and sticky OOR flag.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         op_rd_q  <= 1'b0;
         rvalid_q <= 1'b0;
         wvalid_q <= 1'b0;
         rdata_q  <= '0;
         oor_q    <= 1'b0;
      end else begin
         rvalid_q <= 1'b0;
         wvalid_q <= 1'b0;
         unique case (state_q)
            ST_IDLE: begin
               if (rd_acc_d || wr_acc_d) begin
                  op_rd_q <= rd_acc_d;
                  if (rd_acc_d) begin
                     rdata_q <= rd_word_d;
                  end
                  if (oor_acc_d) begin
                     oor_q <= 1'b1;
                  end
                  if (wait_total_d == '0) begin
                     state_q  <= ST_RESP;
                     rvalid_q <= rd_acc_d;
                     wvalid_q <= wr_acc_d;
                  end else begin
                     state_q <= ST_WAIT;
                     cnt_q   <= wait_total_d;
                  end
               end
            end
            ST_WAIT: begin
               if (cnt_q == CntW'(1)) begin
                  state_q  <= ST_RESP;
                  rvalid_q <= op_rd_q;
                  wvalid_q <= !op_rd_q;
               end else begin
                  cnt_q <= cnt_q - CntW'(1);
               end
            end
            ST_RESP: begin
               state_q <= ST_IDLE;
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.rdata_ready_o = rd_ready_d;
   assign bus.wdata_ready_o = wr_ready_d;
   assign bus.rdata_valid_o = rvalid_q;
   assign bus.wdata_valid_o = wvalid_q;
   assign bus.rdata_data_o  = rdata_q;
   assign bus.oor_flag_o    = oor_q;

endmodule
`default_nettype wire
